riscv_decode_stage: RTL and testbench
=====================================

RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, instruction/PC/immediate width.
REQ-002 SHALL have parameter EXT_M, default 0, 1 enables RV32M decode.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the illegal-instruction counter.
REQ-004 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: in_valid  in  1; in_ready  out  1; inst  in  WORD_LENGTH; pc  in  WORD_LENGTH (upstream handshake and payload).
REQ-007 SHALL have ports: flush  in  1  discard all held entries.
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1 (downstream handshake).
REQ-009 SHALL have outputs: out_pc  WORD_LENGTH; rs1, rs2, rd  5 each; imm  WORD_LENGTH (sign-extended per format); illegal  1.
REQ-010 SHALL have outputs: exec_fun EXEC_FUN; op1_sel OP1_SEL; op2_sel OP2_SEL; wb_sel WB_SEL; rf_wen RF_WEN; mem_wen MEM_WEN; pc_sel PC_SEL; mem_size 2 (0 byte, 1 half, 2 word); mem_unsigned 1.
REQ-011 SHALL have output illegal_cnt  CNT_WIDTH  count of illegal instructions accepted.

Function
REQ-012 SHALL decode all RV32I ops: R/I ALU, shifts, LW/SW, JAL, six branches, plus LUI, AUIPC, JALR, LB/LH/LBU/LHU, SB/SH.
REQ-013 SHALL, when EXT_M=1, decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to EXEC_FUN members ALU_MUL..ALU_REMU added to riscv_defs.sv; when EXT_M=0 these encodings SHALL be illegal.
REQ-014 SHALL give existing ops the same control values as the current RV32I decode table; LUI: ALU_ADD, OP1_X treated as zero operand, OP2_IMU, WB_ALU; AUIPC: OP1_PC, OP2_IMU; JALR: OP1_RS1, OP2_IMI, WB_PC, PC_ALU; new loads/stores as LW/SW with mem_size/mem_unsigned set.
REQ-015 SHALL, for unmatched encodings, assert illegal=1 with controls ALU_X/OP1_X/OP2_X/WB_X/RF_X/MEM_X/PC_PLUS4 and imm=0; illegal instructions still flow through the handshake.
REQ-016 SHALL register decode: an instruction accepted (in_valid&&in_ready) at edge N appears with out_valid=1 after edge N, latency 1 cycle.
REQ-017 SHALL hold two storage entries: output register and skid register; in_ready SHALL be a registered signal equal to "skid entry empty".
REQ-018 SHALL, when out_valid&&!out_ready and a transfer is accepted, place the new decode in the skid entry and drop in_ready next cycle.
REQ-019 SHALL, on output transfer, move skid entry to output register (if occupied) else accept new input directly; simultaneous accept and output transfer with empty skid SHALL keep out_valid=1 with the new entry.
REQ-020 SHALL keep all outputs stable while out_valid&&!out_ready.
REQ-021 SHALL, on flush at an edge, clear both entries (out_valid=0, in_ready=1 next cycle) and ignore any input offered in that cycle; flush has priority over all transfers.
REQ-022 SHALL increment illegal_cnt by 1 when an illegal instruction is accepted, saturating at 2^CNT_WIDTH-1; flushed instructions are still counted.

Reset
REQ-023 SHALL, while rst=1, force out_valid=0, in_ready=1, illegal_cnt=0, all payload registers 0, asynchronously; mid-stream reset discards both entries.
REQ-024 SHALL resume accepting input on the first rising edge after rst deasserts.

Verification
REQ-025 inst=0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, ALU_ADD, OP2_RS2, rd=3, rs1=1, rs2=2, illegal=0.
REQ-026 inst=0x123452B7 (lui x5) -> imm=0x12345000, rd=5, WB_ALU; inst=0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF.
REQ-027 inst=0x022081B3 (mul): EXT_M=1 -> ALU_MUL, illegal=0; EXT_M=0 -> illegal=1, illegal_cnt increments 0->1.
REQ-028 Stream 4 instructions with out_ready=0 -> exactly 2 accepted, in_ready=0; raise out_ready -> outputs in order, none lost or duplicated.
REQ-029 Flush with both entries full -> next cycle out_valid=0, in_ready=1; CNT_WIDTH=2 with 5 illegal inputs -> illegal_cnt saturates at 3.
REQ-030 Assert rst mid-stream with entries held -> out_valid=0, illegal_cnt=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared decode-control encodings for the RISC-V pipeline.
// The "don't care" / inactive member of every enum sits at value 0, so a
// cleared control word is the same as a bubble.
package riscv_defs;

    typedef enum logic [4:0] {
        ALU_X, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
        ALU_BGEU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU,
        ALU_REM, ALU_REMU
    } EXEC_FUN;

    typedef enum logic [1:0] {OP1_X, OP1_RS1, OP1_PC} OP1_SEL;
    typedef enum logic [2:0] {OP2_X, OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMU, OP2_IMJ} OP2_SEL;
    typedef enum logic [1:0] {WB_X, WB_ALU, WB_MEM, WB_PC} WB_SEL;
    typedef enum logic       {RF_X, RF_EN} RF_WEN;
    typedef enum logic       {MEM_X, MEM_EN} MEM_WEN;
    // PC_BR: conditional branch to pc+imm, condition given by exec_fun.
    // PC_ALU: unconditional jump to the ALU result (JAL, JALR).
    typedef enum logic [1:0] {PC_PLUS4, PC_BR, PC_ALU} PC_SEL;

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Handshake and payload bundle of the decode stage.
//   upstream  : in_valid, in_ready, inst, pc, flush
//   downstream: out_valid, out_ready, decoded payload, illegal_cnt
// slave modport is the decode stage; master is the side driving it.
// WORD_LENGTH and CNT_WIDTH must match the attached decode stage.
interface riscv_decode_stage_if #(
    parameter int WORD_LENGTH = 32,
    parameter int CNT_WIDTH   = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_LENGTH-1:0] inst;
    logic [WORD_LENGTH-1:0] pc;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_LENGTH-1:0] out_pc;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [WORD_LENGTH-1:0] imm;
    logic                   illegal;
    riscv_defs::EXEC_FUN    exec_fun;
    riscv_defs::OP1_SEL     op1_sel;
    riscv_defs::OP2_SEL     op2_sel;
    riscv_defs::WB_SEL      wb_sel;
    riscv_defs::RF_WEN      rf_wen;
    riscv_defs::MEM_WEN     mem_wen;
    riscv_defs::PC_SEL      pc_sel;
    logic [1:0]             mem_size;
    logic                   mem_unsigned;
    logic [CNT_WIDTH-1:0]   illegal_cnt;

    modport slave (
        input  in_valid, inst, pc, flush, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, illegal,
               exec_fun, op1_sel, op2_sel, wb_sel, rf_wen, mem_wen, pc_sel,
               mem_size, mem_unsigned, illegal_cnt
    );

    modport master (
        output in_valid, inst, pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, illegal,
               exec_fun, op1_sel, op2_sel, wb_sel, rf_wen, mem_wen, pc_sel,
               mem_size, mem_unsigned, illegal_cnt
    );
endinterface

// File: rtl/riscv_decode_stage.sv
// RV32I (+ optional RV32M) decode stage with a one-cycle registered output
// and a skid entry, so in_ready is a plain flop ("skid empty").
// Ports: clk, rst (async, active-high), bus (riscv_decode_stage_if.slave):
//   upstream in_valid/in_ready/inst/pc, flush, downstream out_valid/out_ready,
//   decoded fields, control selects and a saturating illegal-instruction count.
module riscv_decode_stage
    import riscv_defs::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int EXT_M       = 0,
    parameter int CNT_WIDTH   = 16
) (
    input logic clk,
    input logic rst,
    riscv_decode_stage_if.slave bus
);

    typedef struct packed {
        logic [WORD_LENGTH-1:0] pc;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        logic [WORD_LENGTH-1:0] imm;
        logic                   illegal;
        EXEC_FUN                exec_fun;
        OP1_SEL                 op1_sel;
        OP2_SEL                 op2_sel;
        WB_SEL                  wb_sel;
        RF_WEN                  rf_wen;
        MEM_WEN                 mem_wen;
        PC_SEL                  pc_sel;
        logic [1:0]             mem_size;
        logic                   mem_unsigned;
    } dec_t;

    function automatic logic [WORD_LENGTH-1:0] sext32(input logic [31:0] v);
        return WORD_LENGTH'($signed(v));
    endfunction

    logic [31:0] iw;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    dec_t        dec_p0;

    assign iw     = bus.inst[31:0];
    assign opcode = iw[6:0];
    assign f3     = iw[14:12];
    assign f7     = iw[31:25];

    // Stage 0: combinational decode of the offered instruction
    always_comb begin
        dec_p0.pc           = bus.pc;
        dec_p0.rs1          = iw[19:15];
        dec_p0.rs2          = iw[24:20];
        dec_p0.rd           = iw[11:7];
        dec_p0.imm          = '0;
        dec_p0.illegal      = 1'b0;
        dec_p0.exec_fun     = ALU_X;
        dec_p0.op1_sel      = OP1_X;
        dec_p0.op2_sel      = OP2_X;
        dec_p0.wb_sel       = WB_X;
        dec_p0.rf_wen       = RF_X;
        dec_p0.mem_wen      = MEM_X;
        dec_p0.pc_sel       = PC_PLUS4;
        dec_p0.mem_size     = 2'd0;
        dec_p0.mem_unsigned = 1'b0;
        legal               = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_p0.op1_sel = OP1_RS1;
                dec_p0.op2_sel = OP2_RS2;
                dec_p0.wb_sel  = WB_ALU;
                dec_p0.rf_wen  = RF_EN;
                if (f7 == 7'h01) begin
                    legal = (EXT_M != 0);
                    case (f3)
                        3'd0:    dec_p0.exec_fun = ALU_MUL;
                        3'd1:    dec_p0.exec_fun = ALU_MULH;
                        3'd2:    dec_p0.exec_fun = ALU_MULHSU;
                        3'd3:    dec_p0.exec_fun = ALU_MULHU;
                        3'd4:    dec_p0.exec_fun = ALU_DIV;
                        3'd5:    dec_p0.exec_fun = ALU_DIVU;
                        3'd6:    dec_p0.exec_fun = ALU_REM;
                        default: dec_p0.exec_fun = ALU_REMU;
                    endcase
                end else begin
                    legal = 1'b1;
                    case ({f7, f3})
                        10'b0000000_000: dec_p0.exec_fun = ALU_ADD;
                        10'b0100000_000: dec_p0.exec_fun = ALU_SUB;
                        10'b0000000_001: dec_p0.exec_fun = ALU_SLL;
                        10'b0000000_010: dec_p0.exec_fun = ALU_SLT;
                        10'b0000000_011: dec_p0.exec_fun = ALU_SLTU;
                        10'b0000000_100: dec_p0.exec_fun = ALU_XOR;
                        10'b0000000_101: dec_p0.exec_fun = ALU_SRL;
                        10'b0100000_101: dec_p0.exec_fun = ALU_SRA;
                        10'b0000000_110: dec_p0.exec_fun = ALU_OR;
                        10'b0000000_111: dec_p0.exec_fun = ALU_AND;
                        default:         legal = 1'b0;
                    endcase
                end
            end
            7'b0010011: begin
                dec_p0.op1_sel = OP1_RS1;
                dec_p0.op2_sel = OP2_IMI;
                dec_p0.wb_sel  = WB_ALU;
                dec_p0.rf_wen  = RF_EN;
                dec_p0.imm     = sext32({{20{iw[31]}}, iw[31:20]});
                legal          = 1'b1;
                case (f3)
                    3'd0: dec_p0.exec_fun = ALU_ADD;
                    3'd2: dec_p0.exec_fun = ALU_SLT;
                    3'd3: dec_p0.exec_fun = ALU_SLTU;
                    3'd4: dec_p0.exec_fun = ALU_XOR;
                    3'd6: dec_p0.exec_fun = ALU_OR;
                    3'd7: dec_p0.exec_fun = ALU_AND;
                    3'd1: begin
                        dec_p0.exec_fun = ALU_SLL;
                        legal           = (f7 == 7'h00);
                    end
                    default: begin
                        dec_p0.exec_fun = f7[5] ? ALU_SRA : ALU_SRL;
                        legal           = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                endcase
            end
            7'b0000011: begin
                dec_p0.exec_fun     = ALU_ADD;
                dec_p0.op1_sel      = OP1_RS1;
                dec_p0.op2_sel      = OP2_IMI;
                dec_p0.wb_sel       = WB_MEM;
                dec_p0.rf_wen       = RF_EN;
                dec_p0.imm          = sext32({{20{iw[31]}}, iw[31:20]});
                dec_p0.mem_size     = f3[1:0];
                dec_p0.mem_unsigned = f3[2];
                legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                        (f3 == 3'd4) || (f3 == 3'd5);
            end
            7'b0100011: begin
                dec_p0.exec_fun = ALU_ADD;
                dec_p0.op1_sel  = OP1_RS1;
                dec_p0.op2_sel  = OP2_IMS;
                dec_p0.mem_wen  = MEM_EN;
                dec_p0.imm      = sext32({{20{iw[31]}}, iw[31:25], iw[11:7]});
                dec_p0.mem_size = f3[1:0];
                legal           = (f3 <= 3'd2);
            end
            7'b1100011: begin
                dec_p0.op1_sel = OP1_RS1;
                dec_p0.op2_sel = OP2_RS2;
                dec_p0.pc_sel  = PC_BR;
                dec_p0.imm     = sext32({{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0});
                legal          = 1'b1;
                case (f3)
                    3'd0:    dec_p0.exec_fun = ALU_BEQ;
                    3'd1:    dec_p0.exec_fun = ALU_BNE;
                    3'd4:    dec_p0.exec_fun = ALU_BLT;
                    3'd5:    dec_p0.exec_fun = ALU_BGE;
                    3'd6:    dec_p0.exec_fun = ALU_BLTU;
                    3'd7:    dec_p0.exec_fun = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            7'b1101111: begin
                dec_p0.exec_fun = ALU_ADD;
                dec_p0.op1_sel  = OP1_PC;
                dec_p0.op2_sel  = OP2_IMJ;
                dec_p0.wb_sel   = WB_PC;
                dec_p0.rf_wen   = RF_EN;
                dec_p0.pc_sel   = PC_ALU;
                dec_p0.imm      = sext32({{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0});
                legal           = 1'b1;
            end
            7'b1100111: begin
                dec_p0.exec_fun = ALU_ADD;
                dec_p0.op1_sel  = OP1_RS1;
                dec_p0.op2_sel  = OP2_IMI;
                dec_p0.wb_sel   = WB_PC;
                dec_p0.rf_wen   = RF_EN;
                dec_p0.pc_sel   = PC_ALU;
                dec_p0.imm      = sext32({{20{iw[31]}}, iw[31:20]});
                legal           = (f3 == 3'd0);
            end
            7'b0110111, 7'b0010111: begin
                // LUI adds the U-immediate to a zero operand; AUIPC adds it to pc.
                dec_p0.exec_fun = ALU_ADD;
                dec_p0.op1_sel  = opcode[5] ? OP1_X : OP1_PC;
                dec_p0.op2_sel  = OP2_IMU;
                dec_p0.wb_sel   = WB_ALU;
                dec_p0.rf_wen   = RF_EN;
                dec_p0.imm      = sext32({iw[31:12], 12'h000});
                legal           = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_p0.illegal      = 1'b1;
            dec_p0.exec_fun     = ALU_X;
            dec_p0.op1_sel      = OP1_X;
            dec_p0.op2_sel      = OP2_X;
            dec_p0.wb_sel       = WB_X;
            dec_p0.rf_wen       = RF_X;
            dec_p0.mem_wen      = MEM_X;
            dec_p0.pc_sel       = PC_PLUS4;
            dec_p0.imm          = '0;
            dec_p0.mem_size     = 2'd0;
            dec_p0.mem_unsigned = 1'b0;
        end
    end

    dec_t                 out_p1;
    dec_t                 skid_p1;
    logic                 vld_p1;
    logic                 skid_vld_p1;
    logic                 rdy_p1;
    logic [CNT_WIDTH-1:0] cnt_p1;
    logic                 accept;
    logic                 xfer;

    assign accept = bus.in_valid && rdy_p1;
    assign xfer   = vld_p1 && bus.out_ready;

    // Stage 1: output register + skid entry; rdy_p1 always equals !skid_vld_p1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p1      <= '0;
            skid_p1     <= '0;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
            cnt_p1      <= '0;
        end else begin
            if (accept && !flush_ok() && dec_p0.illegal && (cnt_p1 != {CNT_WIDTH{1'b1}}))
                cnt_p1 <= cnt_p1 + CNT_WIDTH'(1);
            if (bus.flush) begin
                vld_p1      <= 1'b0;
                skid_vld_p1 <= 1'b0;
                rdy_p1      <= 1'b1;
            end else if (xfer) begin
                if (skid_vld_p1) begin
                    out_p1      <= skid_p1;
                    skid_vld_p1 <= 1'b0;
                    rdy_p1      <= 1'b1;
                end else if (accept) begin
                    out_p1 <= dec_p0;
                end else begin
                    vld_p1 <= 1'b0;
                end
            end else if (accept) begin
                if (!vld_p1) begin
                    out_p1 <= dec_p0;
                    vld_p1 <= 1'b1;
                end else begin
                    skid_p1     <= dec_p0;
                    skid_vld_p1 <= 1'b1;
                    rdy_p1      <= 1'b0;
                end
            end
        end
    end

    // Input offered during a flush cycle is discarded, so it is not counted.
    function automatic logic flush_ok();
        return bus.flush;
    endfunction

    assign bus.in_ready     = rdy_p1;
    assign bus.out_valid    = vld_p1;
    assign bus.out_pc       = out_p1.pc;
    assign bus.rs1          = out_p1.rs1;
    assign bus.rs2          = out_p1.rs2;
    assign bus.rd           = out_p1.rd;
    assign bus.imm          = out_p1.imm;
    assign bus.illegal      = out_p1.illegal;
    assign bus.exec_fun     = out_p1.exec_fun;
    assign bus.op1_sel      = out_p1.op1_sel;
    assign bus.op2_sel      = out_p1.op2_sel;
    assign bus.wb_sel       = out_p1.wb_sel;
    assign bus.rf_wen       = out_p1.rf_wen;
    assign bus.mem_wen      = out_p1.mem_wen;
    assign bus.pc_sel       = out_p1.pc_sel;
    assign bus.mem_size     = out_p1.mem_size;
    assign bus.mem_unsigned = out_p1.mem_unsigned;
    assign bus.illegal_cnt  = cnt_p1;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: two instances (EXT_M=1/CNT_WIDTH=16 and
// EXT_M=0/CNT_WIDTH=2) share one stimulus stream. Expected decodes come from a
// mask/match instruction table; the two-entry stage is modelled as a FIFO of
// depth two holding the expected decodes.
module tb_riscv_decode_stage;
    import riscv_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [31:0] inst;
    logic [31:0] pc;

    always #5 clk = ~clk;

    riscv_decode_stage_if #(.WORD_LENGTH(32), .CNT_WIDTH(16)) if_m ();
    riscv_decode_stage_if #(.WORD_LENGTH(32), .CNT_WIDTH(2))  if_b ();

    assign if_m.in_valid  = in_valid;
    assign if_m.inst      = inst;
    assign if_m.pc        = pc;
    assign if_m.flush     = flush;
    assign if_m.out_ready = out_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.inst      = inst;
    assign if_b.pc        = pc;
    assign if_b.flush     = flush;
    assign if_b.out_ready = out_ready;

    riscv_decode_stage #(.WORD_LENGTH(32), .EXT_M(1), .CNT_WIDTH(16)) dut_m (
        .clk(clk), .rst(rst), .bus(if_m));
    riscv_decode_stage #(.WORD_LENGTH(32), .EXT_M(0), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b));

    localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;

    typedef struct {
        logic [31:0] mask, match;
        EXEC_FUN fn; OP1_SEL o1; OP2_SEL o2; WB_SEL wb; RF_WEN rf; MEM_WEN mw; PC_SEL ps;
        int fmt; logic [1:0] sz; logic un; bit needs_m;
    } ent_t;

    typedef struct {
        logic [31:0] pc; logic [14:0] regs; logic [31:0] imm; logic [19:0] ctrl;
    } exp_t;

    typedef struct { exp_t m; exp_t b; } pair_t;

    ent_t  tbl[$];
    pair_t q[$];
    int    cnt_m, cnt_b;
    int    n_assert = 0;
    int    n_fail   = 0;

    function automatic logic [19:0] pk(input logic il, input EXEC_FUN f, input OP1_SEL a,
            input OP2_SEL b, input WB_SEL w, input RF_WEN r, input MEM_WEN m,
            input PC_SEL p, input logic [1:0] s, input logic u);
        return {il, f, a, b, w, r, m, p, s, u};
    endfunction

    function automatic void add(input logic [31:0] mask, input logic [31:0] match,
            input EXEC_FUN fn, input OP1_SEL o1, input OP2_SEL o2, input WB_SEL wb,
            input RF_WEN rf, input MEM_WEN mw, input PC_SEL ps, input int fmt,
            input logic [1:0] sz, input logic un, input bit needs_m);
        ent_t e;
        e.mask = mask; e.match = match; e.fn = fn; e.o1 = o1; e.o2 = o2; e.wb = wb;
        e.rf = rf; e.mw = mw; e.ps = ps; e.fmt = fmt; e.sz = sz; e.un = un; e.needs_m = needs_m;
        tbl.push_back(e);
    endfunction

    function automatic void add_r(input logic [31:0] match, input EXEC_FUN fn, input bit m);
        add(32'hFE00707F, match, fn, OP1_RS1, OP2_RS2, WB_ALU, RF_EN, MEM_X, PC_PLUS4, F_R, 2'd0, 1'b0, m);
    endfunction
    function automatic void add_i(input logic [31:0] mask, input logic [31:0] match, input EXEC_FUN fn);
        add(mask, match, fn, OP1_RS1, OP2_IMI, WB_ALU, RF_EN, MEM_X, PC_PLUS4, F_I, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic void add_ld(input logic [31:0] match, input logic [1:0] sz, input logic un);
        add(32'h0000707F, match, ALU_ADD, OP1_RS1, OP2_IMI, WB_MEM, RF_EN, MEM_X, PC_PLUS4, F_I, sz, un, 1'b0);
    endfunction
    function automatic void add_st(input logic [31:0] match, input logic [1:0] sz);
        add(32'h0000707F, match, ALU_ADD, OP1_RS1, OP2_IMS, WB_X, RF_X, MEM_EN, PC_PLUS4, F_S, sz, 1'b0, 1'b0);
    endfunction
    function automatic void add_br(input logic [31:0] match, input EXEC_FUN fn);
        add(32'h0000707F, match, fn, OP1_RS1, OP2_RS2, WB_X, RF_X, MEM_X, PC_BR, F_B, 2'd0, 1'b0, 1'b0);
    endfunction

    function automatic void build_table();
        add_r(32'h00000033, ALU_ADD, 0);  add_r(32'h40000033, ALU_SUB, 0);
        add_r(32'h00001033, ALU_SLL, 0);  add_r(32'h00002033, ALU_SLT, 0);
        add_r(32'h00003033, ALU_SLTU, 0); add_r(32'h00004033, ALU_XOR, 0);
        add_r(32'h00005033, ALU_SRL, 0);  add_r(32'h40005033, ALU_SRA, 0);
        add_r(32'h00006033, ALU_OR, 0);   add_r(32'h00007033, ALU_AND, 0);
        add_r(32'h02000033, ALU_MUL, 1);  add_r(32'h02001033, ALU_MULH, 1);
        add_r(32'h02002033, ALU_MULHSU, 1); add_r(32'h02003033, ALU_MULHU, 1);
        add_r(32'h02004033, ALU_DIV, 1);  add_r(32'h02005033, ALU_DIVU, 1);
        add_r(32'h02006033, ALU_REM, 1);  add_r(32'h02007033, ALU_REMU, 1);
        add_i(32'h0000707F, 32'h00000013, ALU_ADD);  add_i(32'h0000707F, 32'h00002013, ALU_SLT);
        add_i(32'h0000707F, 32'h00003013, ALU_SLTU); add_i(32'h0000707F, 32'h00004013, ALU_XOR);
        add_i(32'h0000707F, 32'h00006013, ALU_OR);   add_i(32'h0000707F, 32'h00007013, ALU_AND);
        add_i(32'hFE00707F, 32'h00001013, ALU_SLL);  add_i(32'hFE00707F, 32'h00005013, ALU_SRL);
        add_i(32'hFE00707F, 32'h40005013, ALU_SRA);
        add_ld(32'h00000003, 2'd0, 1'b0); add_ld(32'h00001003, 2'd1, 1'b0);
        add_ld(32'h00002003, 2'd2, 1'b0); add_ld(32'h00004003, 2'd0, 1'b1);
        add_ld(32'h00005003, 2'd1, 1'b1);
        add_st(32'h00000023, 2'd0); add_st(32'h00001023, 2'd1); add_st(32'h00002023, 2'd2);
        add_br(32'h00000063, ALU_BEQ);  add_br(32'h00001063, ALU_BNE);
        add_br(32'h00004063, ALU_BLT);  add_br(32'h00005063, ALU_BGE);
        add_br(32'h00006063, ALU_BLTU); add_br(32'h00007063, ALU_BGEU);
        add(32'h0000007F, 32'h0000006F, ALU_ADD, OP1_PC, OP2_IMJ, WB_PC, RF_EN, MEM_X, PC_ALU, F_J, 2'd0, 1'b0, 1'b0);
        add(32'h0000707F, 32'h00000067, ALU_ADD, OP1_RS1, OP2_IMI, WB_PC, RF_EN, MEM_X, PC_ALU, F_I, 2'd0, 1'b0, 1'b0);
        add(32'h0000007F, 32'h00000037, ALU_ADD, OP1_X, OP2_IMU, WB_ALU, RF_EN, MEM_X, PC_PLUS4, F_U, 2'd0, 1'b0, 1'b0);
        add(32'h0000007F, 32'h00000017, ALU_ADD, OP1_PC, OP2_IMU, WB_ALU, RF_EN, MEM_X, PC_PLUS4, F_U, 2'd0, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] imm_of(input int fmt, input logic [31:0] x);
        logic signed [31:0] sx;
        sx = x;
        case (fmt)
            F_I:     return 32'(sx >>> 20);
            F_S:     return (32'(sx >>> 25) << 5) | 32'(x[11:7]);
            F_B:     return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            F_U:     return x & 32'hFFFFF000;
            F_J:     return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] x, input logic [31:0] p, input bit ext_m);
        exp_t e;
        e.pc   = p;
        e.regs = {x[19:15], x[24:20], x[11:7]};
        e.imm  = 32'h0;
        e.ctrl = pk(1'b1, ALU_X, OP1_X, OP2_X, WB_X, RF_X, MEM_X, PC_PLUS4, 2'd0, 1'b0);
        foreach (tbl[i]) begin
            if (((x & tbl[i].mask) == tbl[i].match) && (!tbl[i].needs_m || ext_m)) begin
                e.imm  = imm_of(tbl[i].fmt, x);
                e.ctrl = pk(1'b0, tbl[i].fn, tbl[i].o1, tbl[i].o2, tbl[i].wb, tbl[i].rf,
                            tbl[i].mw, tbl[i].ps, tbl[i].sz, tbl[i].un);
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string nm, input logic ov, input logic ir,
            input logic [63:0] cnt, input int exp_cnt, input logic [31:0] opc,
            input logic [14:0] regs, input logic [31:0] imm, input logic [19:0] ctrl,
            input exp_t e);
        chk({nm, ".out_valid"}, 64'(ov), 64'(q.size() > 0));
        chk({nm, ".in_ready"}, 64'(ir), 64'(q.size() < 2));
        chk({nm, ".illegal_cnt"}, cnt, 64'(exp_cnt));
        if (q.size() > 0) begin
            chk({nm, ".out_pc"}, 64'(opc), 64'(e.pc));
            chk({nm, ".regs"}, 64'(regs), 64'(e.regs));
            chk({nm, ".imm"}, 64'(imm), 64'(e.imm));
            chk({nm, ".ctrl"}, 64'(ctrl), 64'(e.ctrl));
        end
    endtask

    task automatic check_all();
        pair_t f;
        if (q.size() > 0) f = q[0];
        else begin f.m = ref_decode(32'h0, 32'h0, 1'b1); f.b = f.m; end
        check_one("m", if_m.out_valid, if_m.in_ready, 64'(if_m.illegal_cnt), cnt_m, if_m.out_pc,
            {if_m.rs1, if_m.rs2, if_m.rd}, if_m.imm,
            pk(if_m.illegal, if_m.exec_fun, if_m.op1_sel, if_m.op2_sel, if_m.wb_sel, if_m.rf_wen,
               if_m.mem_wen, if_m.pc_sel, if_m.mem_size, if_m.mem_unsigned), f.m);
        check_one("b", if_b.out_valid, if_b.in_ready, 64'(if_b.illegal_cnt), cnt_b, if_b.out_pc,
            {if_b.rs1, if_b.rs2, if_b.rd}, if_b.imm,
            pk(if_b.illegal, if_b.exec_fun, if_b.op1_sel, if_b.op2_sel, if_b.wb_sel, if_b.rf_wen,
               if_b.mem_wen, if_b.pc_sel, if_b.mem_size, if_b.mem_unsigned), f.b);
    endtask

    function automatic void model_reset();
        q.delete();
        cnt_m = 0;
        cnt_b = 0;
    endfunction

    // Depth-two FIFO view of the stage: pop on downstream transfer, push on accept.
    function automatic void model_edge();
        bit    acc;
        pair_t pr;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if ((q.size() > 0) && out_ready) void'(q.pop_front());
            if (acc) begin
                pr.m = ref_decode(inst, pc, 1'b1);
                pr.b = ref_decode(inst, pc, 1'b0);
                q.push_back(pr);
                if (pr.m.ctrl[19] && cnt_m < 65535) cnt_m++;
                if (pr.b.ctrl[19] && cnt_b < 3) cnt_b++;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_inst();
        int i;
        if ($urandom_range(0, 9) < 7) begin
            i = $urandom_range(0, tbl.size() - 1);
            return tbl[i].match | ($urandom & ~tbl[i].mask);
        end
        return $urandom;
    endfunction

    task automatic offer(input logic [31:0] x);
        in_valid = 1'b1;
        inst     = x;
        pc       = pc + 32'd4;
    endtask

    initial begin
        build_table();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; inst = 32'h0; pc = 32'h1000;
        model_reset();
        #12;
        check_all();
        chk("rst.out_pc", 64'(if_m.out_pc), 64'h0);
        chk("rst.imm", 64'(if_m.imm), 64'h0);
        chk("rst.rd", 64'(if_b.rd), 64'h0);
        rst = 1'b0;

        // add x3,x1,x2
        out_ready = 1'b1;
        offer(32'h002081B3);
        step();
        chk("add.exec_fun", 64'(if_m.exec_fun), 64'(ALU_ADD));
        chk("add.op2_sel", 64'(if_m.op2_sel), 64'(OP2_RS2));
        chk("add.rd_rs1_rs2", 64'({if_m.rd, if_m.rs1, if_m.rs2}), 64'({5'd3, 5'd1, 5'd2}));
        chk("add.illegal", 64'(if_m.illegal), 64'h0);

        offer(32'h123452B7);
        step();
        chk("lui.imm", 64'(if_m.imm), 64'h12345000);
        chk("lui.rd", 64'(if_m.rd), 64'd5);
        chk("lui.wb_sel", 64'(if_m.wb_sel), 64'(WB_ALU));
        offer(32'hFFF00093);
        step();
        chk("addi.imm", 64'(if_m.imm), 64'hFFFFFFFF);

        chk("mul.cnt_before", 64'(if_b.illegal_cnt), 64'd0);
        offer(32'h022081B3);
        step();
        chk("mul.m.exec_fun", 64'(if_m.exec_fun), 64'(ALU_MUL));
        chk("mul.m.illegal", 64'(if_m.illegal), 64'h0);
        chk("mul.b.illegal", 64'(if_b.illegal), 64'h1);
        chk("mul.b.cnt", 64'(if_b.illegal_cnt), 64'd1);
        in_valid = 1'b0;
        step();

        // Stall: four offers, only two fit
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(rand_inst());
            step();
        end
        chk("stall.in_ready", 64'(if_m.in_ready), 64'h0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("drain.out_valid", 64'(if_m.out_valid), 64'h0);

        // Flush with both entries full; the input offered with flush is dropped
        out_ready = 1'b0;
        offer(32'h00000000); step();
        offer(32'h00000000); step();
        offer(32'h00000000); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", 64'(if_b.out_valid), 64'h0);
        chk("flush.in_ready", 64'(if_b.in_ready), 64'h1);

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(32'h00000000);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("sat.b.cnt", 64'(if_b.illegal_cnt), 64'd3);

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            inst      = rand_inst();
            pc        = $urandom;
            step();
        end
        flush = 1'b0;

        // Asynchronous reset with both entries held
        out_ready = 1'b0;
        offer(32'h00000000); step();
        offer(32'h00000000); step();
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        chk("arst.m.out_valid", 64'(if_m.out_valid), 64'h0);
        chk("arst.m.cnt", 64'(if_m.illegal_cnt), 64'h0);
        chk("arst.b.in_ready", 64'(if_b.in_ready), 64'h1);
        step();
        rst = 1'b0;
        offer(32'h00A00513);
        step();
        in_valid = 1'b0;
        chk("resume.out_valid", 64'(if_m.out_valid), 64'h1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
